// File: rtl/upsampling_bayes.sv
// 2x2 pixel upsampler: one 24-bit RGB pixel in, a 128-bit block of {P, M, P, M} out,
// where M is the rounded horizontal midpoint with the previous pixel of the same line.
module upsampling_bayes #(
  parameter int PIXEL_WIDTH            = 24,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 128,
  parameter int C_M00_AXIS_START_COUNT = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready
);

  localparam int CNT_W  = $clog2(C_M00_AXIS_START_COUNT + 1);
  localparam int PAD_W  = C_S00_AXIS_TDATA_WIDTH - PIXEL_WIDTH;
  localparam int N_CHAN = PIXEL_WIDTH / 8;

  logic [CNT_W-1:0]       start_cnt;
  logic                   startup_done;
  logic                   xfer;
  logic                   line_start;
  logic [PIXEL_WIDTH-1:0] p_pix;
  logic [PIXEL_WIDTH-1:0] q_pix;
  logic [PIXEL_WIDTH-1:0] q_eff;
  logic [PIXEL_WIDTH-1:0] mid;
  logic [8:0]             chan_sum;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] lane_p;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] lane_m;

  // Packaging-only ports and the alpha byte are intentionally not used.
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axis_aclk, m00_axis_aclk, s00_axis_aresetn,
                       m00_axis_aresetn, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:PIXEL_WIDTH]};

  assign startup_done    = (start_cnt == CNT_W'(C_M00_AXIS_START_COUNT));
  assign s00_axis_tready = startup_done && (!m00_axis_tvalid || m00_axis_tready);
  assign xfer            = s00_axis_tvalid && s00_axis_tready;

  assign p_pix = s00_axis_tdata[PIXEL_WIDTH-1:0];
  assign q_eff = line_start ? p_pix : q_pix;

  // 9-bit per-channel sum so the +1 rounding cannot overflow.
  always_comb begin
    mid      = '0;
    chan_sum = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      chan_sum       = {1'b0, p_pix[c*8 +: 8]} + {1'b0, q_eff[c*8 +: 8]} + 9'd1;
      mid[c*8 +: 8]  = chan_sum[8:1];
    end
  end

  assign lane_p = {{PAD_W{1'b0}}, p_pix};
  assign lane_m = {{PAD_W{1'b0}}, mid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
    end else if (!startup_done) begin
      start_cnt <= start_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pix      <= '0;
      line_start <= 1'b1;
    end else if (xfer) begin
      q_pix      <= p_pix;
      line_start <= s00_axis_tlast;
    end
  end

  // Single output stage; reloads directly when drained and refilled in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else if (xfer) begin
      m00_axis_tdata  <= {lane_m, lane_p, lane_m, lane_p};
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= s00_axis_tlast;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsampling_bayes.sv
// Scoreboard bench for upsampling_bayes: startup, midpoint math, line boundaries,
// back-to-back throughput, backpressure hold and mid-stream reset.
module tb_upsampling_bayes;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  exp_t sb[$];
  logic [23:0]  q_m = '0;
  logic         ls_m = 1'b1;
  logic         hold_pend = 1'b0;
  logic [127:0] hold_data;
  logic         hold_last;

  upsampling_bayes dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_data),
    .s00_axis_tvalid  (s_valid),
    .s00_axis_tlast   (s_last),
    .s00_axis_tready  (s_ready),
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_tdata   (m_data),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tlast   (m_last),
    .m00_axis_tready  (m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  function automatic logic [127:0] block(input logic [23:0] p, input logic [23:0] m);
    return {8'h00, m, 8'h00, p, 8'h00, m, 8'h00, p};
  endfunction

  // Reference model applied at the moment a beat is accepted.
  task automatic push_exp(input logic [31:0] d, input logic last);
    exp_t e;
    logic [23:0] p, q, m;
    p = d[23:0];
    q = ls_m ? p : q_m;
    m = {avg8(p[23:16], q[23:16]), avg8(p[15:8], q[15:8]), avg8(p[7:0], q[7:0])};
    e.data = block(p, m);
    e.last = last;
    sb.push_back(e);
    q_m  = p;
    ls_m = last;
    n_in++;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      push_exp(d, last);
      acc_cyc = cyc;
    end else begin
      chk("send_timeout", s_ready, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_startup(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (s_ready) begin
        n = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
        chk("hold_valid", m_valid, 1'b1);
      end
      hold_pend = 1'b0;
      if (m_valid && !m_ready) begin
        chk("bp_s_ready", s_ready, 1'b0);
        hold_pend = 1'b1;
        hold_data = m_data;
        hold_last = m_last;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", m_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", m_data, e.data);
          chk("out_last", m_last, e.last);
          n_out++;
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    int first_cyc;
    int n;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 128'h0);
    chk("rst_m_last", m_last, 1'b0);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("startup_ready_%0d", i), s_ready, (i == 16));
      chk("startup_m_valid", m_valid, 1'b0);
    end

    send(32'h33221100, 1'b0);
    idle(0);
    @(negedge clk);
    chk("first_px", m_data, 128'h00221100_00221100_00221100_00221100);
    chk("first_valid", m_valid, 1'b1);
    send(32'h44332211, 1'b1);
    idle(0);
    @(negedge clk);
    chk("second_px", m_data, 128'h002B1A09_00332211_002B1A09_00332211);
    idle(3);

    d = 32'h33221100;
    for (int i = 1; i <= 601; i++) begin
      send(d, (i == 601));
      if (i == 1) first_cyc = acc_cyc;
      d = d + 32'h11111111;
    end
    chk("line_b2b_span", 128'(acc_cyc - first_cyc), 128'd600);
    idle(5);

    send(32'h33221100, 1'b0);
    idle(0);
    @(negedge clk);
    chk("line2_first", m_data, 128'h00221100_00221100_00221100_00221100);
    fork
      begin
        logic [31:0] dd;
        dd = 32'h44332211;
        for (int i = 0; i < 30; i++) begin
          send(dd, (i == 29));
          dd = dd + 32'h11111111;
        end
      end
      begin
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(5);
    chk("drain_count", 128'(n_out), 128'(n_in));
    chk("sb_empty", 128'(sb.size()), 128'd0);

    send(32'h55667788, 1'b0);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_m_data", m_data, 128'h0);
    chk("midrst_s_ready", s_ready, 1'b0);
    sb.delete();
    ls_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_startup(n);
    chk("restart_cycles", 128'(n), 128'd16);
    send(32'h44332211, 1'b1);
    idle(0);
    @(negedge clk);
    chk("after_rst_px", m_data, 128'h00332211_00332211_00332211_00332211);
    idle(3);
    chk("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/upsampling_bayes.md
# upsampling_bayes

2x2 pixel upsampler sitting between the input video DMA stream and the 4K output stream. It accepts one 24-bit RGB pixel per 32-bit AXI4-Stream beat. For each input pixel it emits one 128-bit beat carrying a 2x2 block of output pixels: the pixel itself and its horizontal midpoint with the previous pixel, replicated on two rows. Line or packet boundaries are carried through on `tlast`.

## Interface
- `PIXEL_WIDTH`, 24: active pixel bits in the low end of each 32-bit lane; three 8-bit channels.
- `C_S00_AXIS_TDATA_WIDTH`, 32: input beat width; only 32 is supported.
- `C_M00_AXIS_TDATA_WIDTH`, 128: output beat width, four 32-bit lanes; only 128 is supported.
- `C_M00_AXIS_START_COUNT`, 16: clocks after reset release before the block first asserts `s00_axis_tready`.

Ports:
- `clk` in 1: the single clock; all logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s00_axis_aclk`, `m00_axis_aclk` in 1: AXI packaging ports, tied to `clk` at integration, unused internally.
- `s00_axis_aresetn`, `m00_axis_aresetn` in 1: AXI packaging ports, tied to `rst_n`, unused internally.
- `s00_axis_tdata` in 32: input pixel; [23:0] is RGB, [31:24] is ignored.
- `s00_axis_tvalid`, `s00_axis_tlast` in 1: input handshake valid and end-of-line marker.
- `s00_axis_tready` out 1: block can accept an input beat.
- `m00_axis_tdata` out 128: 2x2 output block.
- `m00_axis_tvalid`, `m00_axis_tlast` out 1: output valid and end-of-line marker.
- `m00_axis_tready` in 1: downstream accept.

## Operation
- Startup: after reset release, a counter runs to `C_M00_AXIS_START_COUNT`; `s00_axis_tready` stays 0 until the counter saturates.
- Input transfer: occurs on a clock edge where `s00_axis_tvalid` and `s00_axis_tready` are both 1.
- Pixel and channels: P = `tdata[23:0]`; channels are [23:16], [15:8] and [7:0].
- Previous pixel Q: the pixel of the prior transfer in the same line. For the first pixel after reset, and for the first pixel after any `tlast` transfer, Q = P.
- Midpoint M: per channel, M = (P_ch + Q_ch + 1) >> 1, computed with 9-bit intermediates so there is no overflow.
- Output lanes: lane0 [31:0] = {8'h00, P}, lane1 [63:32] = {8'h00, M}, lane2 [95:64] = {8'h00, P}, lane3 [127:96] = {8'h00, M}.
- Row mapping: lanes 0 and 1 are the upper output row; lanes 2 and 3 are the lower row.
- `m00_axis_tlast` equals the `s00_axis_tlast` of the beat that produced it.
- Q update: Q is replaced by P on every transfer. A `tlast` transfer marks the line as ended, so the next pixel uses Q = P.

## Timing
- Reset values: `s00_axis_tready` = 0, `m00_axis_tvalid` = 0, `m00_axis_tdata` = 0, `m00_axis_tlast` = 0, startup counter = 0, line-start flag = 1.
- Pipeline: one output register stage; an accepted input appears on `m00_*` on the next clock, so latency is 1 cycle.
- `s00_axis_tready` = startup_done && (!`m00_axis_tvalid` || `m00_axis_tready`). This gives full throughput of one beat per clock when downstream is ready.
- Backpressure: while `m00_axis_tvalid` = 1 and `m00_axis_tready` = 0, the output `tdata`, `tlast` and `tvalid` hold stable and no input is accepted.
- Simultaneous events: an output accept and a new input in the same cycle load the register directly; no bubble is inserted.
- Empty output: when the output is accepted and there is no new input, `m00_axis_tvalid` drops to 0 on that edge.
- Mid-stream reset: asserting `rst_n` = 0 clears all state immediately, the pending output is lost, and startup restarts on release.
- `s00_axis_tvalid` low between beats: no state changes and Q is retained.
- Arithmetic: the +0x11111111 input pattern wraps naturally in 32 bits; only [23:0] is used.

## Test plan
- Reset release: `s00_axis_tready` stays 0 for 16 clocks, then goes to 1 with `m00_axis_tready` = 1. `m00_axis_tvalid` stays 0 throughout.
- First pixel 0x33221100: the next cycle gives `m00_axis_tdata` = 0x00221100_00221100_00221100_00221100 and `tvalid` = 1.
- Second pixel 0x44332211 in the same line: M = 0x2B1A09. Output = 0x002B1A09_00332211_002B1A09_00332211.
- 601-beat line (0x33221100 incremented by 0x11111111, `tlast` on beat 601): 601 output beats are produced back to back, with `m00_axis_tlast` = 1 only on the 601st.
- Second line after an idle gap, starting again at 0x33221100: its first output again has all four lanes = 0x00221100, confirming Q was reset at the line boundary.
- Backpressure: hold `m00_axis_tready` = 0 for 5 cycles mid-line. The output is held unchanged, `s00_axis_tready` = 0, and no beats are lost or duplicated after release.
